mem_port_arbiter: RTL

- Round-robin arbiter and sequencer for one shared memory port with two requesters: requester 0 (instruction fetch) and requester 1 (data access).
- Grants one requester at a time and drives the select line of the 2-to-1 address/data multiplexer in front of the port.
- Times each access with a fixed-latency counter and returns a one-cycle completion pulse to the granted requester.
- Sits between the pipeline front end / memory stage and the single-ported memory model.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port with two requesters.
// Each grant occupies the port for LATENCY cycles, followed by one idle cycle.
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic select_o,
    output logic mem_en_o,
    output logic done0_o,
    output logic done1_o,
    output logic busy_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             r_owner;
    logic             w_owner_n;
    logic             r_last;
    logic             w_last_n;
    logic             r_first;
    logic             w_first_n;
    logic             w_winner;
    logic             w_access;
    logic             w_cnt_zero;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_owner <= w_owner_n;
            r_last  <= w_last_n;
            r_first <= w_first_n;
        end
    end

    // On a tie the requester that did not win last time gets the port.
    assign w_winner = (req0_i && req1_i) ? ~r_last : req1_i;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_owner_n = r_owner;
        w_last_n  = r_last;
        w_first_n = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req0_i || req1_i) begin
                    w_state_n = ACCESS;
                    w_cnt_n   = LOAD;
                    w_owner_n = w_winner;
                    w_last_n  = w_winner;
                    w_first_n = 1'b1;
                end
            end
            ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end else begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign w_access   = (r_state == ACCESS);
    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        gnt0_o   = w_access & ~r_owner;
        gnt1_o   = w_access & r_owner;
        select_o = r_owner;
        busy_o   = w_access;
        mem_en_o = w_access & r_first;
        done0_o  = w_access & ~r_owner & w_cnt_zero;
        done1_o  = w_access & r_owner & w_cnt_zero;
    end

endmodule
